// File: rtl/cnn_layer_accel_ce_macc_ctrl_if.sv
// rtl/cnn_layer_accel_ce_macc_ctrl_if.sv - job, operand and result handshakes of the MACC sequencer
interface cnn_layer_accel_ce_macc_ctrl_if #(
  parameter int A_W   = 30,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int LEN_W = 16
);
  logic                  cfg_start;
  logic [LEN_W-1:0]      cfg_len;
  logic                  busy;
  logic                  op_valid;
  logic                  op_ready;
  logic signed [A_W-1:0] op_a;
  logic signed [B_W-1:0] op_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [P_W-1:0]        res_data;

  modport master (
    output cfg_start, cfg_len, op_valid, op_a, op_b, res_ready,
    input  busy, op_ready, res_valid, res_data
  );

  modport slave (
    input  cfg_start, cfg_len, op_valid, op_a, op_b, res_ready,
    output busy, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/cnn_layer_accel_ce_macc_ctrl.sv
// rtl/cnn_layer_accel_ce_macc_ctrl.sv - sequencer driving one pipelined MACC slice to sum a job of products
module cnn_layer_accel_ce_macc_ctrl #(
  parameter int A_W   = 30,
  parameter int B_W   = 18,
  parameter int P_W   = 48,
  parameter int LEN_W = 16
) (
  input  logic           CLK,
  input  logic           rst,
  cnn_layer_accel_ce_macc_ctrl_if.slave ctl,
  output logic [A_W-1:0] macc_A,
  output logic [B_W-1:0] macc_B,
  output logic [8:0]     macc_opmode,
  output logic [3:0]     macc_alumode,
  output logic           macc_CE,
  input  logic [P_W-1:0] macc_P
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic             first;
  tag_t             t1, t2, t3, t4;
  logic             res_valid_q;
  logic [P_W-1:0]   res_data_q;

  logic stall;
  logic op_ready;
  logic fire;
  logic ce;
  logic capture;
  logic rem_is_one;

  assign rem_is_one = (rem == LEN_W'(1));
  assign stall      = t4.v & t4.last & res_valid_q & ~ctl.res_ready;
  assign op_ready   = (state == RUN) & (rem != '0) & ~stall;
  assign fire       = ctl.op_valid & op_ready;
  assign ce         = fire | ((state == DRAIN) & ~stall);
  // Last tag sitting in t4 means P holds the final sum on this cycle.
  assign capture    = (state == DRAIN) & t4.v & t4.last & ~stall;

  assign ctl.busy      = (state != IDLE);
  assign ctl.op_ready  = op_ready;
  assign ctl.res_valid = res_valid_q;
  assign ctl.res_data  = res_data_q;

  assign macc_A       = ctl.op_a;
  assign macc_B       = ctl.op_b;
  assign macc_alumode = 4'b0000;
  assign macc_CE      = ce;

  // t2 sits beside A2, so its opmode lands in OPMODEREG together with M.
  always_comb begin
    macc_opmode = 9'b000100000;
    if (t2.v) begin
      macc_opmode = t2.first ? 9'b000000101 : 9'b000100101;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      first       <= 1'b0;
      t1          <= '0;
      t2          <= '0;
      t3          <= '0;
      t4          <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      if (ce) begin
        t1 <= tag_t'{fire, fire & first, fire & rem_is_one};
        t2 <= t1;
        t3 <= t2;
        t4 <= t3;
      end

      case (state)
        IDLE: begin
          if (ctl.cfg_start && (ctl.cfg_len != '0)) begin
            state <= RUN;
            rem   <= ctl.cfg_len;
            first <= 1'b1;
          end
        end
        RUN: begin
          if (fire) begin
            rem   <= rem - LEN_W'(1);
            first <= 1'b0;
            if (rem_is_one) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (capture) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (capture) begin
        res_data_q  <= macc_P;
        res_valid_q <= 1'b1;
      end else if (ctl.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule
